// File: rtl/buf_release_queue.sv
`default_nettype none
// ============================================================================
// Module   : buf_release_queue
// Brief    : Release-side companion to the buffer allocator. Returned buffer
//            addresses are queued in a small FIFO and drained at most one per
//            cycle as a registered free strobe plus address.
// Option   : BUF_REL_FILTER_EN - shadow ownership bitmap that drops releases
//            of buffers not currently allocated and pulses o_dup_err.
// Revision : 1.0 - initial release
// ============================================================================
module buf_release_queue #(
  parameter int ADDR_W = 4,
  parameter int DEPTH  = 8
) (
  input  logic                     i_clock,
  input  logic                     i_reset,
  input  logic                     i_alloc_ok,
  input  logic [ADDR_W-1:0]        i_alloc_addr,
  input  logic                     i_rel_valid,
  input  logic [ADDR_W-1:0]        i_rel_addr,
  output logic                     o_rel_ready,
  output logic                     o_free,
  output logic [ADDR_W-1:0]        o_free_addr,
  output logic [$clog2(DEPTH):0]   o_fifo_count,
  output logic                     o_dup_err
);

  localparam int c_PTR_W = $clog2(DEPTH);
  localparam int c_CNT_W = c_PTR_W + 1;

  localparam logic [c_CNT_W-1:0] c_DEPTH_CNT = c_CNT_W'(DEPTH);
  localparam logic [c_CNT_W-1:0] c_CNT_ONE   = c_CNT_W'(1);
  localparam logic [c_PTR_W-1:0] c_PTR_ONE   = c_PTR_W'(1);

  logic [ADDR_W-1:0]  r_mem [DEPTH];
  logic [c_PTR_W-1:0] r_wr_ptr;
  logic [c_PTR_W-1:0] r_rd_ptr;
  logic [c_CNT_W-1:0] r_count;
  logic               r_free;
  logic [ADDR_W-1:0]  r_free_addr;

  logic w_ready;
  logic w_accept;
  logic w_push;
  logic w_pop;

  // Ready depends only on pre-edge occupancy: a same-cycle pop never makes
  // room for a push into a full queue.
  assign w_ready  = (r_count < c_DEPTH_CNT);
  assign w_accept = i_rel_valid & w_ready;
  assign w_pop    = (r_count != '0);

`ifdef BUF_REL_FILTER_EN
  localparam int c_NBUF = 1 << ADDR_W;

  logic [c_NBUF-1:0] r_bitmap;
  logic [c_NBUF-1:0] w_bitmap_nxt;
  logic              w_owned;
  logic              r_dup_err;

  // A release is judged on the pre-edge ownership bit.
  assign w_owned = r_bitmap[i_rel_addr];
  assign w_push  = w_accept & w_owned;

  // Clear on a surviving release first, then set on grant so that a grant of
  // the same address in the same cycle leaves the buffer owned.
  always_comb begin
    w_bitmap_nxt = r_bitmap;
    if (w_push) begin
      w_bitmap_nxt[i_rel_addr] = 1'b0;
    end
    if (i_alloc_ok) begin
      w_bitmap_nxt[i_alloc_addr] = 1'b1;
    end
  end

  // Ownership bitmap and drop pulse registers.
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_bitmap  <= '0;
      r_dup_err <= 1'b0;
    end else begin
      r_bitmap  <= w_bitmap_nxt;
      r_dup_err <= w_accept & ~w_owned;
    end
  end

  assign o_dup_err = r_dup_err;
`else
  logic w_unused_alloc;

  // Without the filter every accepted release is queued and grants are ignored.
  assign w_push         = w_accept;
  assign w_unused_alloc = i_alloc_ok ^ (^i_alloc_addr);
  assign o_dup_err      = 1'b0;
`endif

  // Storage array; contents are don't-care while empty so no reset needed.
  always_ff @(posedge i_clock) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= i_rel_addr;
    end
  end

  // Pointers wrap naturally; occupancy is tracked by a separate counter.
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + c_CNT_ONE;
        2'b01:   r_count <= r_count - c_CNT_ONE;
        default: r_count <= r_count;
      endcase
    end
  end

  // Drain one entry per cycle onto the allocator's free port; address holds
  // its last value when nothing is freed.
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_free      <= 1'b0;
      r_free_addr <= '0;
    end else begin
      r_free <= w_pop;
      if (w_pop) begin
        r_free_addr <= r_mem[r_rd_ptr];
      end
    end
  end

  assign o_rel_ready  = w_ready;
  assign o_free       = r_free;
  assign o_free_addr  = r_free_addr;
  assign o_fifo_count = r_count;

endmodule
`default_nettype wire
